// File: rtl/posit_encoder_8_bit.sv
// posit_encoder_8_bit
//   Packs decoded 8-bit (es=0) posit fields back into a posit word.
//   Two-stage valid/ready pipeline:
//     S1: regime/fraction packing into a 7-bit magnitude, rounding, clamping
//     S2: sign application and special values (output register)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       input fields valid          in_ready   encoder can accept
//   in_inf_zero    {inf, zero} special flags   in_sign    1 = negative
//   in_regime      biased regime code (value = code - 7, legal 1..13)
//   in_fraction    fraction bits MSB first, hidden bit excluded
//   in_guard       first bit below in_fraction
//   in_sticky      OR of all bits below guard
//   out_valid      out_posit valid             out_ready  downstream accepts
//   out_posit      encoded posit               out_saturated  result clamped
//
// Build option:
//   POSIT_ENCODER_ROUND_NEAREST_EN  defined: round-to-nearest-even;
//                                   undefined: truncation (guard/sticky ignored)

module posit_encoder_8_bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_inf_zero,
  input  logic       in_sign,
  input  logic [3:0] in_regime,
  input  logic [4:0] in_fraction,
  input  logic       in_guard,
  input  logic       in_sticky,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_posit,
  output logic       out_saturated
);

  logic       s1_v, s2_v;
  logic       s1_sign, s1_inf, s1_zero, s1_sat;
  logic [6:0] s1_mag;

  logic       s2_adv, s1_load, s2_load;

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_v && s2_adv;
  assign out_valid = s2_v;

  // Magnitude build. The regime pattern occupies the top len bits of a
  // 13-bit window; fraction and guard are shifted in directly beneath it,
  // so the kept magnitude is w[12:6], the round bit is w[5] and the
  // remaining bits fold into sticky.
  logic [12:0] pat, w;
  logic [3:0]  shamt;
  logic [6:0]  mag_c;
  logic        sat_c;

`ifdef POSIT_ENCODER_ROUND_NEAREST_EN
  logic        rnd, stk;
  logic [7:0]  sum;
`else
  logic        unused_trunc;
  assign unused_trunc = ^{w[5:0], in_sticky};
`endif

  always_comb begin
    pat = '0;
    for (int unsigned i = 0; i < 13; i++) begin
      if (in_regime >= 4'd7) begin
        if (i < 32'(in_regime) - 32'd6) pat[12-i] = 1'b1;
      end else begin
        if (i == 32'd7 - 32'(in_regime)) pat[12-i] = 1'b1;
      end
    end
    // shamt = 7 - len; len = code-5 (r >= 0) or 8-code (r < 0)
    shamt = (in_regime >= 4'd7) ? (4'd12 - in_regime) : (in_regime - 4'd1);
    w     = pat | ({7'b0, in_fraction, in_guard} << shamt);

`ifdef POSIT_ENCODER_ROUND_NEAREST_EN
    rnd   = w[5];
    stk   = (|w[4:0]) | in_sticky;
    sum   = {1'b0, w[12:6]} + 8'(rnd & (stk | w[6]));
    if (sum[7]) begin
      mag_c = 7'h7F;
      sat_c = 1'b1;
    end else begin
      mag_c = sum[6:0];
      sat_c = 1'b0;
    end
`else
    mag_c = w[12:6];
    sat_c = 1'b0;
`endif

    if (in_regime == 4'd0) begin
      mag_c = 7'h01;
      sat_c = 1'b1;
    end else if (in_regime >= 4'd14) begin
      mag_c = 7'h7F;
      sat_c = 1'b1;
    end else if (in_regime == 4'd13) begin
      mag_c = 7'h7F;
`ifdef POSIT_ENCODER_ROUND_NEAREST_EN
      sat_c = (|in_fraction) | in_guard | in_sticky;
`else
      sat_c = |in_fraction;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s1_sign       <= 1'b0;
      s1_inf        <= 1'b0;
      s1_zero       <= 1'b0;
      s1_sat        <= 1'b0;
      s1_mag        <= '0;
      s2_v          <= 1'b0;
      out_posit     <= '0;
      out_saturated <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v    <= 1'b1;
        s1_sign <= in_sign;
        s1_inf  <= in_inf_zero[1];
        s1_zero <= in_inf_zero[0];
        s1_sat  <= sat_c;
        s1_mag  <= mag_c;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        s2_v <= 1'b1;
        if (s1_inf) begin
          out_posit     <= 8'h80;
          out_saturated <= 1'b0;
        end else if (s1_zero) begin
          out_posit     <= 8'h00;
          out_saturated <= 1'b0;
        end else begin
          out_posit     <= s1_sign ? (8'd0 - {1'b0, s1_mag}) : {1'b0, s1_mag};
          out_saturated <= s1_sat;
        end
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder_8_bit.sv
module tb_posit_encoder_8_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_inf_zero = '0;
  logic       in_sign = 1'b0;
  logic [3:0] in_regime = 4'd7;
  logic [4:0] in_fraction = '0;
  logic       in_guard = 1'b0;
  logic       in_sticky = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_posit;
  logic       out_saturated;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic [8:0] exp_q[$];   // {saturated, posit}
  logic       hold_v = 1'b0;
  logic [8:0] hold_val;
  logic       rand_bp = 1'b0;

  always #5 clk = ~clk;

  posit_encoder_8_bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inf_zero  (in_inf_zero),
    .in_sign      (in_sign),
    .in_regime    (in_regime),
    .in_fraction  (in_fraction),
    .in_guard     (in_guard),
    .in_sticky    (in_sticky),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_posit    (out_posit),
    .out_saturated(out_saturated)
  );

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: append posit bits one at a time, then round on what falls off.
  function automatic logic [8:0] model(input logic [1:0] iz, input logic s,
                                       input logic [3:0] code, input logic [4:0] f,
                                       input logic g, input logic st);
    logic       bits [16];
    int         n;
    logic [6:0] mag;
    logic       sat;
    logic [7:0] p;
    logic       rnd, stk;
    if (iz[1]) return {1'b0, 8'h80};
    if (iz[0]) return {1'b0, 8'h00};
    sat = 1'b0;
    if (code == 0) begin
      mag = 7'h01; sat = 1'b1;
    end else if (code >= 14) begin
      mag = 7'h7F; sat = 1'b1;
    end else if (code == 13) begin
      mag = 7'h7F;
`ifdef POSIT_ENCODER_ROUND_NEAREST_EN
      sat = (f != 0) || g || st;
`else
      sat = (f != 0);
`endif
    end else begin
      for (int i = 0; i < 16; i++) bits[i] = 1'b0;
      n = 0;
      if (code >= 7) begin
        for (int i = 0; i < int'(code) - 6; i++) begin bits[n] = 1'b1; n++; end
        bits[n] = 1'b0; n++;
      end else begin
        for (int i = 0; i < 7 - int'(code); i++) begin bits[n] = 1'b0; n++; end
        bits[n] = 1'b1; n++;
      end
      for (int i = 4; i >= 0; i--) begin bits[n] = f[i]; n++; end
      bits[n] = g; n++;
      for (int i = 0; i < 7; i++) mag[6-i] = bits[i];
      rnd = bits[7];
      stk = st;
      for (int i = 8; i < 16; i++) stk = stk | bits[i];
`ifdef POSIT_ENCODER_ROUND_NEAREST_EN
      if (rnd && (stk || mag[0])) begin
        if (mag == 7'h7F) sat = 1'b1;
        else mag = mag + 7'd1;
      end
`else
      if (rnd || stk) sat = sat;
`endif
    end
    p = s ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    return {sat, p};
  endfunction

  task automatic send(input logic [1:0] iz, input logic s, input logic [3:0] code,
                      input logic [4:0] f, input logic g, input logic st,
                      input logic [8:0] exp);
    logic acc;
    acc = 1'b0;
    in_inf_zero = iz; in_sign = s; in_regime = code;
    in_fraction = f; in_guard = g; in_sticky = st;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        n_acc++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", {8'b0, in_ready}, 9'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [1:0] iz, input logic s, input logic [3:0] code,
                        input logic [4:0] f, input logic g, input logic st);
    send(iz, s, code, f, g, st, model(iz, s, code, f, g, st));
  endtask

  // Output monitor: scoreboard pop on transfer, stability while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v) begin
        check("hold_valid", {8'b0, out_valid}, 9'd1);
        check("hold_stable", {out_saturated, out_posit}, hold_val);
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_saturated, out_posit};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {8'b0, out_valid}, 9'd0);
        else check("posit", {out_saturated, out_posit}, exp_q.pop_front());
      end
    end
  end

  always @(negedge rst_n) begin
    hold_v = 1'b0;
    exp_q.delete();
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {8'b0, out_valid}, 9'd0);
    check("rst_out_posit", {1'b0, out_posit}, 9'h000);
    check("rst_out_sat", {8'b0, out_saturated}, 9'd0);
    check("rst_in_ready", {8'b0, in_ready}, 9'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values with fixed expectations
    send(2'b00, 1'b0, 4'd7,  5'b00000, 1'b0, 1'b0, {1'b0, 8'h40});
    send(2'b00, 1'b1, 4'd7,  5'b00000, 1'b0, 1'b0, {1'b0, 8'hC0});
    send(2'b00, 1'b0, 4'd8,  5'b10000, 1'b0, 1'b0, {1'b0, 8'h68});
`ifdef POSIT_ENCODER_ROUND_NEAREST_EN
    send(2'b00, 1'b0, 4'd7,  5'b11111, 1'b1, 1'b0, {1'b0, 8'h60});
`else
    send(2'b00, 1'b0, 4'd7,  5'b11111, 1'b1, 1'b0, {1'b0, 8'h5F});
`endif
    send(2'b00, 1'b0, 4'd13, 5'b00001, 1'b0, 1'b0, {1'b1, 8'h7F});
    send(2'b00, 1'b0, 4'd13, 5'b00000, 1'b0, 1'b0, {1'b0, 8'h7F});
    send(2'b00, 1'b1, 4'd15, 5'b00000, 1'b0, 1'b0, {1'b1, 8'h81});
    send(2'b00, 1'b0, 4'd14, 5'b01010, 1'b0, 1'b0, {1'b1, 8'h7F});
    send(2'b00, 1'b0, 4'd0,  5'b00000, 1'b0, 1'b0, {1'b1, 8'h01});
    send(2'b00, 1'b0, 4'd1,  5'b00000, 1'b0, 1'b0, {1'b0, 8'h01});
    send(2'b00, 1'b0, 4'd12, 5'b00000, 1'b0, 1'b0, {1'b0, 8'h7E});
    send(2'b10, 1'b1, 4'd15, 5'b11111, 1'b1, 1'b1, {1'b0, 8'h80});
    send(2'b01, 1'b1, 4'd0,  5'b10101, 1'b1, 1'b1, {1'b0, 8'h00});
    send(2'b11, 1'b0, 4'd13, 5'b11111, 1'b0, 1'b0, {1'b0, 8'h80});
    repeat (4) @(posedge clk); #1;

    // Back-pressure: two accepts, then in_ready must fall
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send_m(2'b00, 1'b0, 4'd9,  5'b01100, 1'b0, 1'b0);
        send_m(2'b00, 1'b1, 4'd5,  5'b10011, 1'b1, 1'b0);
        send_m(2'b00, 1'b0, 4'd10, 5'b00111, 1'b1, 1'b1);
        send_m(2'b00, 1'b1, 4'd11, 5'b11000, 1'b0, 1'b1);
        send_m(2'b00, 1'b0, 4'd3,  5'b01011, 1'b1, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready", {8'b0, in_ready}, 9'd0);
        check("bp_accepts", 9'(n_acc), 9'd2);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Reset mid-stream with two words in flight
    out_ready = 1'b0;
    send_m(2'b00, 1'b0, 4'd8, 5'b11100, 1'b0, 1'b0);
    send_m(2'b00, 1'b1, 4'd6, 5'b00110, 1'b1, 1'b1);
    check("mid_full_in_ready", {8'b0, in_ready}, 9'd0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {8'b0, out_valid}, 9'd0);
    check("mid_rst_posit", {1'b0, out_posit}, 9'h000);
    check("mid_rst_in_ready", {8'b0, in_ready}, 9'd1);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale", {8'b0, out_valid}, 9'd0);
    end
    @(posedge clk); #1;
    send(2'b00, 1'b0, 4'd8, 5'b10000, 1'b0, 1'b0, {1'b0, 8'h68});

    // Randomised stream with random output stalls
    rand_bp = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [1:0] iz;
      iz = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_m(iz, 1'($urandom), 4'($urandom_range(0, 15)), 5'($urandom),
             1'($urandom), 1'($urandom));
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 9'(exp_q.size()), 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
